// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the iterative 32-bit multiply/divide datapath.
// Walks IDLE -> INIT -> RUN (32 iterations) -> DONE and drives the init/step
// strobes, the 5-bit bit-select index and a one-cycle ready pulse.
// Optional feature macro: MULTDIV_DIV0_EN. When it is defined, a divide by
// zero short-circuits straight to DONE and raises data_exception.
module multdiv_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandB,
  input  logic        dp_ovf,
  output logic        dp_init,
  output logic        dp_step,
  output logic        dp_op_div,
  output logic [4:0]  sel,
  output logic        busy,
  output logic        data_resultRDY,
  output logic        data_exception
);

  typedef enum logic [1:0] {StIdle, StInit, StRun, StDone} state_e;

  state_e     state_q, state_d;
  logic [4:0] sel_q, sel_d;
  logic       op_div_q, op_div_d;
  logic       init_q, init_d;
  logic       step_q, step_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       req;

`ifdef MULTDIV_DIV0_EN
  logic       div0_q, div0_d;
`else
  // Operand B only feeds the zero check, which is absent in this build.
  logic       unused_operand_b;
  assign unused_operand_b = ^data_operandB;
`endif

  assign req = ctrl_MULT | ctrl_DIV;

  // Next-state logic; a request in any state (re)starts the sequence.
  always_comb begin
    state_d  = state_q;
    sel_d    = 5'd0;
    op_div_d = op_div_q;
`ifdef MULTDIV_DIV0_EN
    div0_d   = div0_q;
`endif
    if (req) begin
      // Multiply wins when both request pulses arrive together.
      op_div_d = ctrl_DIV & ~ctrl_MULT;
      state_d  = StInit;
`ifdef MULTDIV_DIV0_EN
      div0_d   = op_div_d & (data_operandB == 32'd0);
      if (div0_d) begin
        state_d = StDone;
      end
`endif
    end else begin
      case (state_q)
        StIdle: state_d = StIdle;
        StInit: state_d = StRun;
        StRun: begin
          if (sel_q == 5'd31) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            sel_d   = sel_q + 5'd1;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    // Outputs are decoded from the next state so they come straight from flops.
    init_d = (state_d == StInit);
    step_d = (state_d == StRun);
    busy_d = init_d | step_d;
    done_d = (state_d == StDone);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      sel_q    <= 5'd0;
      op_div_q <= 1'b0;
      init_q   <= 1'b0;
      step_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULTDIV_DIV0_EN
      div0_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      op_div_q <= op_div_d;
      init_q   <= init_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef MULTDIV_DIV0_EN
      div0_q   <= div0_d;
`endif
    end
  end

  assign dp_init   = init_q;
  assign dp_step   = step_q;
  assign dp_op_div = op_div_q;
  assign sel       = sel_q;
  assign busy      = busy_q;

  // A restart arriving in DONE swallows that DONE's ready pulse.
  assign data_resultRDY = done_q & ~req;

  // Overflow is produced by the datapath during DONE, so it is used as-is.
`ifdef MULTDIV_DIV0_EN
  assign data_exception = data_resultRDY & (op_div_q ? div0_q : dp_ovf);
`else
  assign data_exception = data_resultRDY & ~op_div_q & dp_ovf;
`endif

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl. Expected exception values are queued
// when a request is issued and popped when the ready pulse is due.
module tb_multdiv_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandB = 32'd0;
  logic        dp_ovf = 1'b0;
  logic        dp_init, dp_step, dp_op_div, busy, data_resultRDY, data_exception;
  logic [4:0]  sel;

`ifdef MULTDIV_DIV0_EN
  localparam bit Div0En = 1'b1;
`else
  localparam bit Div0En = 1'b0;
`endif

  multdiv_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandB  (data_operandB),
    .dp_ovf         (dp_ovf),
    .dp_init        (dp_init),
    .dp_step        (dp_step),
    .dp_op_div      (dp_op_div),
    .sel            (sel),
    .busy           (busy),
    .data_resultRDY (data_resultRDY),
    .data_exception (data_exception)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int rdy_cnt = 0;
  bit exp_q[$];

  logic [10:0] obs;
  assign obs = {dp_init, dp_step, dp_op_div, busy, data_resultRDY, data_exception, sel};

  always @(posedge clock) begin
    if (data_resultRDY === 1'b1) rdy_cnt <= rdy_cnt + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive a one-cycle request and queue the exception the model predicts.
  task automatic issue(input bit m, input bit d, input logic [31:0] b, input bit restart);
    bit isdiv;
    bit exc;
    isdiv = d & ~m;
    if (restart) exp_q.delete();
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandB = b;
    #1;
    if (restart) begin
      n_cmp++;
      if (data_resultRDY !== 1'b0) begin
        n_bad++;
        $display("FAIL restart_rdy_gate: got %b want 0", data_resultRDY);
      end
    end
    exc = isdiv ? (Div0En && b == 32'd0) : dp_ovf;
    exp_q.push_back(exc);
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandB = $urandom;
    #1;
  endtask

  // Called in C1 of an operation; checks INIT, the sweep and DONE.
  task automatic run_op(input string name, input bit isdiv, input int abort_at,
                        input bit stop_in_done);
    logic [10:0] want;
    logic [4:0]  ks;
    bit          e;
    want = {1'b1, 1'b0, isdiv, 1'b1, 1'b0, 1'b0, 5'd0};
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s init: got %h want %h", name, obs, want);
    end
    for (int k = 0; k < 32; k++) begin
      tick();
      ks = k[4:0];
      want = {1'b0, 1'b1, isdiv, 1'b1, 1'b0, 1'b0, ks};
      n_cmp++;
      if (obs !== want) begin
        n_bad++;
        $display("FAIL %s run%0d: got %h want %h", name, k, obs, want);
      end
      if (k == abort_at) return;
    end
    tick();
    if (stop_in_done) return;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s scoreboard: got empty queue want one entry", name);
      e = 1'b0;
    end else begin
      e = exp_q.pop_front();
    end
    want = {1'b0, 1'b0, isdiv, 1'b0, 1'b1, e, 5'd0};
    n_cmp++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s done: got %h want %h", name, obs, want);
    end
    tick();
    n_cmp++;
    if ({busy, data_resultRDY} !== 2'b00) begin
      n_bad++;
      $display("FAIL %s idle: got busy/rdy %b want 00", name, {busy, data_resultRDY});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 000", obs);
    end
  endtask

  task automatic test_mult();
    dp_ovf = 1'b0;
    issue(1'b1, 1'b0, 32'h1234_5678, 1'b0);
    run_op("mult", 1'b0, -1, 1'b0);
  endtask

  task automatic test_mult_ovf();
    dp_ovf = 1'b1;
    issue(1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
    run_op("mult_ovf", 1'b0, -1, 1'b0);
    dp_ovf = 1'b0;
  endtask

  task automatic test_div();
    issue(1'b0, 1'b1, 32'd7, 1'b0);
    run_op("div", 1'b1, -1, 1'b0);
  endtask

  task automatic test_div0();
    logic [10:0] want;
    bit          e;
    int          r0;
    r0 = rdy_cnt;
    issue(1'b0, 1'b1, 32'd0, 1'b0);
    if (Div0En) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b0;
      want = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, e, 5'd0};
      n_cmp++;
      if (obs !== want || e !== 1'b1) begin
        n_bad++;
        $display("FAIL div0_short: got %h want %h", obs, {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0});
      end
      tick();
      n_cmp++;
      if ({dp_init, dp_step, busy, data_resultRDY} !== 4'b0000) begin
        n_bad++;
        $display("FAIL div0_after: got %b want 0000",
                 {dp_init, dp_step, busy, data_resultRDY});
      end
      n_cmp++;
      if (rdy_cnt - r0 != 1) begin
        n_bad++;
        $display("FAIL div0_rdy_count: got %0d want 1", rdy_cnt - r0);
      end
    end else begin
      run_op("div0_full", 1'b1, -1, 1'b0);
    end
  endtask

  task automatic test_both();
    dp_ovf = 1'b0;
    issue(1'b1, 1'b1, 32'd0, 1'b0);
    run_op("both_req", 1'b0, -1, 1'b0);
  endtask

  task automatic test_abort();
    int r0;
    r0 = rdy_cnt;
    issue(1'b1, 1'b0, 32'd3, 1'b0);
    run_op("abort_first", 1'b0, 10, 1'b0);
    issue(1'b0, 1'b1, 32'd9, 1'b1);
    run_op("abort_second", 1'b1, -1, 1'b0);
    n_cmp++;
    if (rdy_cnt - r0 != 1) begin
      n_bad++;
      $display("FAIL abort_rdy_count: got %0d want 1", rdy_cnt - r0);
    end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = rdy_cnt;
    issue(1'b1, 1'b0, 32'd5, 1'b0);
    run_op("b2b_first", 1'b0, -1, 1'b1);
    issue(1'b1, 1'b0, 32'd6, 1'b1);
    run_op("b2b_second", 1'b0, -1, 1'b0);
    n_cmp++;
    if (rdy_cnt - r0 != 1) begin
      n_bad++;
      $display("FAIL b2b_rdy_count: got %0d want 1", rdy_cnt - r0);
    end
  endtask

  task automatic test_reset_mid_run();
    int r0;
    issue(1'b1, 1'b0, 32'd11, 1'b0);
    run_op("reset_mid", 1'b0, 20, 1'b0);
    exp_q.delete();
    r0 = rdy_cnt;
    reset = 1'b1;
    ctrl_DIV = 1'b1;
    tick();
    reset = 1'b0;
    ctrl_DIV = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 11'd0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %h want 000", obs);
    end
    for (int i = 0; i < 40; i++) tick();
    n_cmp++;
    if (rdy_cnt != r0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_quiet: got rdy %0d busy %b want rdy 0 busy 0",
               rdy_cnt - r0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_mult_ovf();
    test_div();
    test_div0();
    test_both();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
